// File: rtl/ipb_pkg.sv
// Shared types and defaults for the input process block.
// It is the write-direction path that moves bytes from the TX FIFO or SRAM into the flash.
package ipb_pkg;

  localparam int DATA_W_DEFAULT     = 8;
  localparam int PAGE_BYTES_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SWAIT,
    DRIVE,
    DONE
  } ipb_state_t;

  typedef enum logic {
    SRC_FIFO = 1'b0,
    SRC_SRAM = 1'b1
  } ipb_src_t;

endpackage

// File: rtl/ipb_down_counter.sv
// Remaining-byte counter for one burst.
// It loads the clamped count, steps down once per accepted byte and flags the last and empty values.
module ipb_down_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk2,
  input  logic             NReset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_last,
  output logic             is_zero
);

  logic [CNT_W-1:0] remaining;

  always_ff @(posedge clk2) begin
    if (!NReset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_val;
    end else if (dec && (remaining != '0)) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign is_last = (remaining == CNT_W'(1));
  assign is_zero = (remaining == '0);

endmodule

// File: rtl/input_process_block.sv
// Burst engine that fetches bytes from the TX FIFO or the SRAM and hands each one to the flash.
// Each byte goes out with a write strobe that is held until the flash accepts it.
module input_process_block
  import ipb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int PAGE_BYTES = PAGE_BYTES_DEFAULT,
  parameter int CNT_W      = $clog2(PAGE_BYTES + 1)
) (
  input  logic              clk2,
  input  logic              NReset,
  input  logic              start,
  input  logic              Input_control,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] Out_SRAM,
  output logic              sram_rd,
  input  logic              flash_ready,
  output logic [DATA_W-1:0] FDataIn,
  output logic              FWrite,
  output logic              busy,
  output logic              done
);

  ipb_state_t        state_q, state_d;
  ipb_src_t          src_q;
  logic [DATA_W-1:0] hold_q;
  logic [CNT_W-1:0]  clamped_count;
  logic              cnt_load, cnt_dec, cnt_last, cnt_zero;

  assign clamped_count = (byte_count > CNT_W'(PAGE_BYTES)) ? CNT_W'(PAGE_BYTES) : byte_count;

  ipb_down_counter #(.CNT_W(CNT_W)) u_counter (
    .clk2     (clk2),
    .NReset   (NReset),
    .load     (cnt_load),
    .load_val (clamped_count),
    .dec      (cnt_dec),
    .is_last  (cnt_last),
    .is_zero  (cnt_zero)
  );

  // Source select is frozen at the accepted start so mid-burst toggles are harmless.
  always_ff @(posedge clk2) begin
    if (!NReset) begin
      state_q <= IDLE;
      src_q   <= SRC_FIFO;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        src_q <= ipb_src_t'(Input_control);
      end
      if (fifo_rd) begin
        hold_q <= fifo_rdata;
      end else if (state_q == SWAIT) begin
        hold_q <= Out_SRAM;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_rd  = 1'b0;
    sram_rd  = 1'b0;
    FWrite   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_load = 1'b1;
          state_d  = (clamped_count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else if (src_q == SRC_SRAM) begin
          sram_rd = 1'b1;
          state_d = SWAIT;
        end else if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = DRIVE;
        end
      end
      SWAIT: begin
        state_d = DRIVE;
      end
      DRIVE: begin
        FWrite = 1'b1;
        if (flash_ready) begin
          cnt_dec = 1'b1;
          state_d = cnt_last ? DONE : FETCH;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign FDataIn = FWrite ? hold_q : '0;

endmodule

// File: tb/tb_input_process_block.sv
// Randomized scoreboard bench for input_process_block with behavioural FIFO/SRAM/flash models.
// Expected bytes are queued when a burst is issued; the negedge monitor pops them on each accepted write.
module tb_input_process_block;

  localparam int DATA_W     = 8;
  localparam int PAGE_BYTES = 64;
  localparam int CNT_W      = 7;

  logic              clk2 = 1'b0;
  logic              NReset;
  logic              start;
  logic              Input_control;
  logic [CNT_W-1:0]  byte_count;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_rdata = '0;
  logic              fifo_rd;
  logic [DATA_W-1:0] Out_SRAM = '0;
  logic              sram_rd;
  logic              flash_ready;
  logic [DATA_W-1:0] FDataIn;
  logic              FWrite;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] user_q[$];
  logic [7:0] pending_q[$];
  logic [7:0] mem[256];
  logic [7:0] sram_ptr = 8'd0;

  int  pops, sreads, writes, done_cnt;
  int  first_fw_cyc, first_acc_cyc, last_acc_cyc, done_cyc;
  bit  pop_req, sram_req, prev_hold;
  logic [7:0] prev_data;

  input_process_block #(.DATA_W(DATA_W), .PAGE_BYTES(PAGE_BYTES), .CNT_W(CNT_W)) dut (
    .clk2          (clk2),
    .NReset        (NReset),
    .start         (start),
    .Input_control (Input_control),
    .byte_count    (byte_count),
    .fifo_empty    (fifo_empty),
    .fifo_rdata    (fifo_rdata),
    .fifo_rd       (fifo_rd),
    .Out_SRAM      (Out_SRAM),
    .sram_rd       (sram_rd),
    .flash_ready   (flash_ready),
    .FDataIn       (FDataIn),
    .FWrite        (FWrite),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk2 = ~clk2;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic rnd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // Source models: pops and SRAM reads take effect just after the edge that consumed them,
  // and the FIFO flags are refreshed once all same-cycle pushes from the stimulus are in.
  always @(posedge clk2) begin
    cyc++;
    #1;
    if (pop_req && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
    if (sram_req) begin
      Out_SRAM = mem[sram_ptr];
      sram_ptr = sram_ptr + 8'd1;
    end else begin
      Out_SRAM = 8'($urandom);
    end
    #1;
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? 8'($urandom) : fifo_q[0];
  end

  // Monitor and scoreboard consumer.
  always @(negedge clk2) begin
    pop_req  = fifo_rd;
    sram_req = sram_rd;
    if (fifo_rd) begin
      pops++;
      checkOutput("rd_when_empty", fifo_empty, 0);
    end
    if (sram_rd) sreads++;
    if (!FWrite) checkOutput("fdatain_idle_zero", FDataIn, 0);
    if (prev_hold && NReset) checkOutput("hold_stable", {FWrite, FDataIn}, {1'b1, prev_data});
    if (FWrite && (first_fw_cyc < 0)) first_fw_cyc = cyc;
    if (FWrite && flash_ready) begin
      checkOutput("write_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) checkOutput("write_data", FDataIn, exp_q.pop_front());
      writes++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    prev_hold = NReset && FWrite && !flash_ready;
    prev_data = FDataIn;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      checkOutput("done_busy", busy, 1);
    end
  end

  task automatic applyStimulus(input bit src, input int cnt, input int ready_pct,
                               input int first_stall, input bit holdback, input bit noisy);
    int n, done0, push_cyc;
    bit finished;
    logic [7:0] b, base;
    n = (cnt > PAGE_BYTES) ? PAGE_BYTES : cnt;
    pops = 0; sreads = 0; writes = 0;
    first_fw_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
    done0 = done_cnt; push_cyc = -1; finished = 0;
    base = sram_ptr;
    for (int i = 0; i < n; i++) begin
      if (src) b = mem[base + 8'(i)];
      else if (user_q.size() > 0) b = user_q.pop_front();
      else b = 8'($urandom);
      if (!src) begin
        if (!holdback || (i == 0)) fifo_q.push_back(b);
        else pending_q.push_back(b);
      end
      exp_q.push_back(b);
    end
    @(posedge clk2); #1;
    start = 1'b1;
    Input_control = src;
    byte_count = CNT_W'(cnt);
    start_cyc = cyc;
    flash_ready = (first_stall > 0) ? 1'b0 : rnd(ready_pct);
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk2); #1;
      if (done_cnt != done0) begin
        start = 1'b0;
        finished = 1;
        break;
      end
      start = noisy ? 1'($urandom) : 1'b0;
      if (noisy) begin
        Input_control = 1'($urandom);
        byte_count = CNT_W'($urandom);
      end
      if (holdback && (pending_q.size() > 0) && (first_acc_cyc >= 0) && (cyc >= first_acc_cyc + 10)) begin
        while (pending_q.size() > 0) fifo_q.push_back(pending_q.pop_front());
        push_cyc = cyc;
      end
      if ((first_stall > 0) && ((first_fw_cyc < 0) || (cyc < first_fw_cyc + first_stall)))
        flash_ready = 1'b0;
      else
        flash_ready = rnd(ready_pct);
    end
    start = 1'b0;
    if (!finished) $display("[TB] FAIL burst_timeout src=%0d cnt=%0d", src, cnt);
    checkOutput("done_once", done_cnt - done0, 1);
    checkOutput("exp_drained", exp_q.size(), 0);
    checkOutput("write_count", writes, n);
    checkOutput("src_reads", src ? sreads : pops, n);
    checkOutput("other_src_reads", src ? pops : sreads, 0);
    if (n == 0) checkOutput("zero_done_lat", done_cyc, start_cyc + 1);
    else checkOutput("done_lat", done_cyc, last_acc_cyc + 1);
    if ((n > 0) && (ready_pct == 100) && (first_stall == 0) && !holdback) begin
      checkOutput("first_fwrite_lat", first_fw_cyc, start_cyc + (src ? 3 : 2));
      checkOutput("throughput", last_acc_cyc, start_cyc + n * (src ? 3 : 2));
    end
    if (first_stall > 0) checkOutput("stall_hold_len", first_acc_cyc - first_fw_cyc, first_stall);
    if (holdback && (n > 1)) checkOutput("underflow_resume", last_acc_cyc, push_cyc + 1);
    @(negedge clk2);
    checkOutput("idle_after", {busy, done, FWrite}, 0);
    exp_q.delete();
    pending_q.delete();
  endtask

  initial begin : main
    int done0;
    logic [7:0] b;
    NReset = 1'b0; start = 1'b0; Input_control = 1'b0;
    byte_count = '0; flash_ready = 1'b0;
    done_cnt = 0; pops = 0; sreads = 0; writes = 0;
    first_fw_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk2);
    @(negedge clk2);
    checkOutput("reset_outputs", {fifo_rd, sram_rd, FWrite, busy, done, FDataIn}, 0);
    @(posedge clk2); #1;
    NReset = 1'b1;

    user_q = '{8'hA1, 8'hB2, 8'hC3};
    applyStimulus(1'b0, 3, 100, 0, 1'b0, 1'b0);

    mem[sram_ptr] = 8'h5A;
    mem[sram_ptr + 8'd1] = 8'h6B;
    applyStimulus(1'b1, 2, 100, 4, 1'b0, 1'b0);

    applyStimulus(1'b0, 2, 100, 0, 1'b1, 1'b0);

    applyStimulus(1'b0, 0, 100, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 100, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 100, 70, 0, 1'b0, 1'b0);

    // Abort a four-byte burst while byte 2 sits in DRIVE.
    done0 = done_cnt; writes = 0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      fifo_q.push_back(b);
      exp_q.push_back(b);
    end
    @(posedge clk2); #1;
    start = 1'b1; Input_control = 1'b0; byte_count = CNT_W'(4); flash_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk2); #1;
      start = 1'b0;
      if (writes >= 1) break;
    end
    flash_ready = 1'b0;
    @(posedge clk2); #1;
    NReset = 1'b0;
    @(negedge clk2);
    checkOutput("drive_before_reset", FWrite, 1);
    @(posedge clk2); #1;
    @(negedge clk2);
    checkOutput("abort_outputs", {fifo_rd, sram_rd, FWrite, busy, done, FDataIn}, 0);
    checkOutput("abort_no_done", done_cnt - done0, 0);
    exp_q.delete();
    fifo_q.delete();
    @(posedge clk2); #1;
    NReset = 1'b1; flash_ready = 1'b1;
    applyStimulus(1'b0, 4, 100, 0, 1'b0, 1'b0);

    applyStimulus(1'b0, 5, 80, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4, 100, 0, 1'b0, 1'b1);

    for (int r = 0; r < 10; r++) begin
      applyStimulus(1'($urandom_range(1)), int'($urandom_range(70)),
                    int'($urandom_range(100, 50)), 0, 1'b0, 1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
